// File: rtl/alt_vipvfr121_common_avalon_mm_ctrl_master.sv
// Avalon-MM control master for a VIP core control slave. It runs one command
// at a time (single write, single read, or masked poll with a retry limit)
// and returns a one-cycle response with the last read data and a status code.
module alt_vipvfr121_common_avalon_mm_ctrl_master #(
    parameter int unsigned AV_ADDRESS_WIDTH = 5,
    parameter int unsigned AV_DATA_WIDTH    = 16,
    parameter int unsigned POLL_CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [AV_ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [AV_DATA_WIDTH-1:0]    cmd_data,
    input  logic [AV_DATA_WIDTH-1:0]    cmd_mask,
    input  logic [POLL_CNT_WIDTH-1:0]   poll_limit,
    output logic                        rsp_valid,
    output logic [AV_DATA_WIDTH-1:0]    rsp_data,
    output logic [1:0]                  rsp_status,
    output logic [AV_ADDRESS_WIDTH-1:0] av_address,
    output logic                        av_read,
    output logic                        av_write,
    output logic [AV_DATA_WIDTH-1:0]    av_writedata,
    input  logic [AV_DATA_WIDTH-1:0]    av_readdata,
    input  logic                        av_readdatavalid,
    input  logic                        av_waitrequest
);

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_POLL    = 2'b10;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_POLL_GAP,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    // Registered outputs
    logic                        cmd_ready_q, cmd_ready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [AV_DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic [1:0]                  rsp_status_q, rsp_status_d;
    logic [AV_ADDRESS_WIDTH-1:0] av_address_q, av_address_d;
    logic                        av_read_q, av_read_d;
    logic                        av_write_q, av_write_d;
    logic [AV_DATA_WIDTH-1:0]    av_writedata_q, av_writedata_d;

    // Command fields latched at accept, plus the poll retry counter
    logic [1:0]                  op_q, op_d;
    logic [AV_DATA_WIDTH-1:0]    cmp_q, cmp_d;
    logic [AV_DATA_WIDTH-1:0]    mask_q, mask_d;
    logic [POLL_CNT_WIDTH-1:0]   limit_q, limit_d;
    logic [POLL_CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic accept_c;
    logic rd_done_c;
    logic match_c;
    logic limit_hit_c;
    logic poll_retry_c;

    // cmd_ready_q is only high in IDLE, so this is the accept handshake
    assign accept_c     = cmd_valid & cmd_ready_q;
    // Read data is only taken while a read is outstanding; stray valids elsewhere are dropped
    assign rd_done_c    = ((state_q == S_RD_REQ) & ~av_waitrequest & av_readdatavalid)
                        | ((state_q == S_RD_WAIT) & av_readdatavalid);
    assign match_c      = ((av_readdata ^ cmp_q) & mask_q) == '0;
    assign limit_hit_c  = (cnt_q == limit_q);
    assign poll_retry_c = rd_done_c & (op_q == OP_POLL) & ~match_c & ~limit_hit_c;

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_status   = rsp_status_q;
    assign av_address   = av_address_q;
    assign av_read      = av_read_q;
    assign av_write     = av_write_q;
    assign av_writedata = av_writedata_q;

    // State and registered outputs; reset abandons any in-flight transfer silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_status_q   <= ST_OK;
            av_address_q   <= '0;
            av_read_q      <= 1'b0;
            av_write_q     <= 1'b0;
            av_writedata_q <= '0;
            op_q           <= OP_WRITE;
            cmp_q          <= '0;
            mask_q         <= '0;
            limit_q        <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_status_q   <= rsp_status_d;
            av_address_q   <= av_address_d;
            av_read_q      <= av_read_d;
            av_write_q     <= av_write_d;
            av_writedata_q <= av_writedata_d;
            op_q           <= op_d;
            cmp_q          <= cmp_d;
            mask_q         <= mask_d;
            limit_q        <= limit_d;
            cnt_q          <= cnt_d;
        end
    end

    // Next-state sequencing of the bus cycle for the current command
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    case (cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD_REQ;
                        OP_POLL:  state_d = S_RD_REQ;
                        default:  state_d = S_RESP;
                    endcase
                end
            end
            S_WR: begin
                if (!av_waitrequest) state_d = S_RESP;
            end
            S_RD_REQ: begin
                if (!av_waitrequest) begin
                    if (av_readdatavalid) state_d = poll_retry_c ? S_POLL_GAP : S_RESP;
                    else                  state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (av_readdatavalid) state_d = poll_retry_c ? S_POLL_GAP : S_RESP;
            end
            S_POLL_GAP: state_d = S_RD_REQ;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, command latches and retry counter
    always_comb begin
        cmd_ready_d    = (state_d == S_IDLE);
        av_read_d      = (state_d == S_RD_REQ);
        av_write_d     = (state_d == S_WR);
        rsp_valid_d    = (state_d == S_RESP);
        av_address_d   = av_address_q;
        av_writedata_d = av_writedata_q;
        rsp_data_d     = rsp_data_q;
        rsp_status_d   = rsp_status_q;
        op_d           = op_q;
        cmp_d          = cmp_q;
        mask_d         = mask_q;
        limit_d        = limit_q;
        cnt_d          = cnt_q;

        if (accept_c) begin
            op_d         = cmd_op;
            av_address_d = cmd_address;
            cmp_d        = cmd_data;
            mask_d       = cmd_mask;
            limit_d      = poll_limit;
            cnt_d        = '0;
            if (cmd_op == OP_WRITE) av_writedata_d = cmd_data;
        end

        if (poll_retry_c) cnt_d = cnt_q + POLL_CNT_WIDTH'(1);

        if (state_d == S_RESP) begin
            if (state_q == S_IDLE) begin
                rsp_data_d   = '0;
                rsp_status_d = ST_ILLEGAL;
            end else if (state_q == S_WR) begin
                rsp_data_d   = '0;
                rsp_status_d = ST_OK;
            end else begin
                rsp_data_d   = av_readdata;
                rsp_status_d = ((op_q == OP_POLL) && !match_c) ? ST_TIMEOUT : ST_OK;
            end
        end
    end

endmodule

// File: tb/tb_alt_vipvfr121_common_avalon_mm_ctrl_master.sv
// Bench for the Avalon-MM control master: directed cases followed by random
// commands against a reactive slave, with responses predicted from a
// register-file and read-sequence model.
module tb_alt_vipvfr121_common_avalon_mm_ctrl_master;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] cmd_mask;
    logic [CW-1:0] poll_limit;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic [AW-1:0] av_address;
    logic          av_read;
    logic          av_write;
    logic [DW-1:0] av_writedata;
    logic [DW-1:0] av_readdata;
    logic          av_readdatavalid;
    logic          av_waitrequest;

    alt_vipvfr121_common_avalon_mm_ctrl_master #(
        .AV_ADDRESS_WIDTH(AW),
        .AV_DATA_WIDTH   (DW),
        .POLL_CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_address     (cmd_address),
        .cmd_data        (cmd_data),
        .cmd_mask        (cmd_mask),
        .poll_limit      (poll_limit),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_status      (rsp_status),
        .av_address      (av_address),
        .av_read         (av_read),
        .av_write        (av_write),
        .av_writedata    (av_writedata),
        .av_readdata     (av_readdata),
        .av_readdatavalid(av_readdatavalid),
        .av_waitrequest  (av_waitrequest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment state
    logic [DW-1:0] slv_mem   [1<<AW];
    logic [DW-1:0] model_mem [1<<AW];
    logic [DW-1:0] rd_script [$];
    logic [AW-1:0] rd_addrs  [$];
    int            force_wait = -1;
    int            force_lat  = -1;
    bit            slave_en   = 1'b1;
    int            wr_count   = 0;
    int            rd_count   = 0;
    int            last_n     = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    int            rsp_pulses   = 0;
    int            wr_hi_cycles = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Count response strobes and write-strobe cycles
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_pulses++;
        if (av_write === 1'b1) wr_hi_cycles++;
    end

    // Serve one bus request seen at this falling edge
    task automatic serve();
        int            n;
        int            lat;
        bit            is_rd;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [DW-1:0] v;
        is_rd = av_read;
        a0    = av_address;
        d0    = av_writedata;
        check_eq("rw_excl", 32'(av_read & av_write), 0);
        n = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        av_readdatavalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            av_waitrequest = 1'b1;
            @(negedge clk);
            check_eq("hold_addr", 32'(av_address), 32'(a0));
            check_eq("hold_strobe", 32'(is_rd ? av_read : av_write), 1);
            if (!is_rd) check_eq("hold_wdata", 32'(av_writedata), 32'(d0));
        end
        av_waitrequest = 1'b0;
        if (!is_rd) begin
            last_n       = n;
            wr_count++;
            last_wr_addr = a0;
            last_wr_data = d0;
            slv_mem[a0]  = d0;
            @(negedge clk);
            check_eq("wr_drop", 32'(av_write), 0);
        end else begin
            rd_count++;
            rd_addrs.push_back(a0);
            v   = (rd_script.size() > 0) ? rd_script.pop_front() : slv_mem[a0];
            lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            if (lat == 0) begin
                av_readdatavalid = 1'b1;
                av_readdata      = v;
                @(negedge clk);
                check_eq("rd_drop", 32'(av_read), 0);
                av_readdatavalid = 1'b0;
            end else begin
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (i == 0) check_eq("rd_drop", 32'(av_read), 0);
                end
                av_readdatavalid = 1'b1;
                av_readdata      = v;
                @(negedge clk);
                av_readdatavalid = 1'b0;
            end
        end
    endtask

    // Reactive slave; when idle it sprinkles stray readdatavalid pulses
    initial begin
        av_waitrequest   = 1'b0;
        av_readdatavalid = 1'b0;
        av_readdata      = '0;
        forever begin
            @(negedge clk);
            if (slave_en && !rst && (av_read === 1'b1 || av_write === 1'b1)) begin
                serve();
            end else if (slave_en) begin
                av_waitrequest   = 1'b0;
                av_readdatavalid = ($urandom_range(0, 3) == 0);
                av_readdata      = DW'($urandom);
            end
        end
    end

    // Issue one command, predict its outcome and check the bus and response
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] m, input logic [CW-1:0] lim);
        int            exp_reads;
        int            exp_writes;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_status;
        logic [DW-1:0] v;
        int            budget;
        int            wr0, rd0, p0, whi0, t_acc, t_rsp;

        exp_reads  = 0;
        exp_writes = 0;
        exp_data   = '0;
        exp_status = 2'b00;
        case (op)
            2'b00: exp_writes = 1;
            2'b01: begin
                exp_reads = 1;
                exp_data  = (rd_script.size() > 0) ? rd_script[0] : model_mem[a];
            end
            2'b10: begin
                exp_reads  = int'(lim) + 1;
                exp_status = 2'b01;
                for (int i = 0; i <= int'(lim); i++) begin
                    v        = (i < rd_script.size()) ? rd_script[i] : model_mem[a];
                    exp_data = v;
                    if ((v & m) == (d & m)) begin
                        exp_reads  = i + 1;
                        exp_status = 2'b00;
                        break;
                    end
                end
            end
            default: exp_status = 2'b10;
        endcase

        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        check_eq("ready_idle", 32'(cmd_ready), 1);

        wr0  = wr_count;
        rd0  = rd_count;
        p0   = rsp_pulses;
        whi0 = wr_hi_cycles;
        rd_addrs.delete();
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_address = a;
        cmd_data    = d;
        cmd_mask    = m;
        poll_limit  = lim;
        t_acc       = cyc;
        tick();
        cmd_valid   = 1'b0;
        cmd_op      = 2'($urandom);
        cmd_address = AW'($urandom);
        cmd_data    = DW'($urandom);
        cmd_mask    = DW'($urandom);
        poll_limit  = CW'($urandom);
        check_eq("ready_busy", 32'(cmd_ready), 0);

        budget = 0;
        while (rsp_valid !== 1'b1 && budget < 400) begin
            tick();
            budget++;
        end
        check_eq("rsp_seen", 32'(rsp_valid), 1);
        t_rsp = cyc;
        check_eq("rsp_data", 32'(rsp_data), 32'(exp_data));
        check_eq("rsp_status", 32'(rsp_status), 32'(exp_status));
        check_eq("ready_in_rsp", 32'(cmd_ready), 0);
        tick();
        check_eq("rsp_one_cycle", 32'(rsp_valid), 0);
        check_eq("ready_after", 32'(cmd_ready), 1);
        check_eq("rsp_data_hold", 32'(rsp_data), 32'(exp_data));
        check_eq("rsp_pulses", 32'(rsp_pulses - p0), 1);
        check_eq("n_writes", 32'(wr_count - wr0), 32'(exp_writes));
        check_eq("n_reads", 32'(rd_count - rd0), 32'(exp_reads));
        foreach (rd_addrs[i]) check_eq("rd_addr", 32'(rd_addrs[i]), 32'(a));
        if (op == 2'b00) begin
            check_eq("wr_addr", 32'(last_wr_addr), 32'(a));
            check_eq("wr_data", 32'(last_wr_data), 32'(d));
            check_eq("wr_hi_cycles", 32'(wr_hi_cycles - whi0), 32'(last_n + 1));
            check_eq("wr_latency", 32'(t_rsp - t_acc), 32'(last_n + 2));
            model_mem[a] = d;
        end
        if (op == 2'b11) check_eq("ill_latency", 32'(t_rsp - t_acc), 1);
        rd_script.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] d, m;
        logic [CW-1:0] lim;
        int            p0;
        int            ns;

        for (int i = 0; i < (1 << AW); i++) begin
            slv_mem[i]   = DW'($urandom);
            model_mem[i] = slv_mem[i];
        end
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_address = '0;
        cmd_data    = '0;
        cmd_mask    = '0;
        poll_limit  = '0;
        tick();
        tick();
        check_eq("rst_ready", 32'(cmd_ready), 1);
        check_eq("rst_read", 32'(av_read), 0);
        check_eq("rst_write", 32'(av_write), 0);
        check_eq("rst_addr", 32'(av_address), 0);
        check_eq("rst_wdata", 32'(av_writedata), 0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_data", 32'(rsp_data), 0);
        check_eq("rst_rsp_status", 32'(rsp_status), 0);
        rst = 1'b0;
        tick();

        // Zero-waitstate write, then a write stalled for three cycles
        force_wait = 0;
        run_cmd(2'b00, 5'd0, 16'h0001, 16'h0000, 16'd0);
        force_wait = 3;
        run_cmd(2'b00, 5'd3, 16'h1234, 16'h0000, 16'd0);

        // Read with two-cycle data latency, then with data in the accept cycle
        force_wait = 0;
        force_lat  = 2;
        rd_script.push_back(16'h0001);
        run_cmd(2'b01, 5'd1, 16'h0000, 16'h0000, 16'd0);
        force_lat = 0;
        rd_script.push_back(16'h0001);
        run_cmd(2'b01, 5'd1, 16'h0000, 16'h0000, 16'd0);
        force_wait = -1;
        force_lat  = -1;

        // Poll that succeeds on the fourth read
        rd_script = '{16'h0000, 16'h0000, 16'h0000, 16'h0001};
        run_cmd(2'b10, 5'd1, 16'h0001, 16'h0001, 16'd10);
        // Poll that times out after limit+1 reads
        rd_script = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_cmd(2'b10, 5'd1, 16'h0001, 16'h0001, 16'd2);
        // Limit zero gives a single read; zero mask matches immediately
        rd_script = '{16'h0000, 16'h0000};
        run_cmd(2'b10, 5'd2, 16'h0001, 16'h0001, 16'd0);
        rd_script = '{16'hA5A5};
        run_cmd(2'b10, 5'd2, 16'h5A5A, 16'h0000, 16'd7);
        // Reserved opcode
        run_cmd(2'b11, 5'd4, 16'hFFFF, 16'hFFFF, 16'd3);

        // Reset in the middle of an outstanding read
        slave_en = 1'b0;
        av_waitrequest   = 1'b0;
        av_readdatavalid = 1'b0;
        cmd_valid   = 1'b1;
        cmd_op      = 2'b01;
        cmd_address = 5'd6;
        tick();
        cmd_valid = 1'b0;
        check_eq("mid_rdreq", 32'(av_read), 1);
        tick();
        check_eq("mid_rdwait", 32'(av_read), 0);
        p0  = rsp_pulses;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_read", 32'(av_read), 0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 1);
        check_eq("mid_rst_rsp", 32'(rsp_valid), 0);
        check_eq("mid_rst_addr", 32'(av_address), 0);
        tick();
        rst = 1'b0;
        av_readdatavalid = 1'b1;
        av_readdata      = 16'hBEEF;
        tick();
        tick();
        av_readdatavalid = 1'b0;
        tick();
        tick();
        check_eq("late_rdv_no_rsp", 32'(rsp_pulses - p0), 0);
        check_eq("late_rdv_ready", 32'(cmd_ready), 1);
        check_eq("late_rdv_data", 32'(rsp_data), 0);
        slave_en = 1'b1;
        run_cmd(2'b00, 5'd6, 16'hC0DE, 16'h0000, 16'd0);

        // Random commands against random waitstates and read latencies
        for (int k = 0; k < 200; k++) begin
            op  = 2'($urandom_range(0, 3));
            a   = AW'($urandom);
            d   = DW'($urandom);
            case ($urandom_range(0, 3))
                0:       m = '0;
                1:       m = DW'(1) << $urandom_range(0, DW - 1);
                default: m = DW'($urandom);
            endcase
            lim = CW'($urandom_range(0, 5));
            rd_script.delete();
            if (op == 2'b01 || op == 2'b10) begin
                ns = int'($urandom_range(0, int'(lim) + 1));
                for (int j = 0; j < ns; j++) begin
                    case ($urandom_range(0, 2))
                        0:       rd_script.push_back(d);
                        1:       rd_script.push_back(d ^ m);
                        default: rd_script.push_back(DW'($urandom));
                    endcase
                end
            end
            run_cmd(op, a, d, m, lim);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
